customcrc_axil_slave: RTL
=========================

# customcrc_axil_slave

AXI4-Lite slave CRC-32 peripheral; it is the responder end of the 4-register S00_AXI interface that the customCRC master BFM drives. It holds a control/seed/data/result register map and runs a byte-serial CRC-32 engine, polynomial 0x04C11DB7, non-reflected, no final XOR. Each accepted DATA write folds one 32-bit word into the running CRC.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register.
- CRC_POLY, 32'h04C11DB7, generator polynomial.
- SEED_RESET, 32'hFFFFFFFF, reset value of SEED and RESULT.

Ports:
- s00_axi_aclk  in  1  clock; the block has one clock.
- s00_axi_areset  in  1  reset, synchronous and active-high.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel; arprot is ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.

## Operation
Register map. addr[1:0] is ignored.
- 0x0 CTRL.
  - bit0 CLEAR: writing 1 loads RESULT with SEED. This bit self-clears and always reads 0.
  - bit1 BUSY: read-only.
  - All other bits read 0.
- 0x4 SEED: read/write, byte-masked by wstrb.
- 0x8 DATA: read/write, byte-masked by wstrb. An accepted write starts the engine on the merged word. Reads return the last written word.
- 0xC RESULT: read-only. Writes are ignored and still answered with OKAY.

Write path:
- awready and wready pulse high together for one cycle. Condition: awvalid and wvalid both high, bvalid low, and engine idle.
- Writes are stalled (no ready) while BUSY.
- bvalid rises on the cycle after the handshake and holds until bready.
- bresp is always 2'b00.

Read path:
- arready pulses for one cycle when arvalid is high and rvalid is low.
- rdata and rvalid are registered on the next cycle. rvalid holds, with rdata stable, until rready.
- rresp is always 2'b00.
- Reads are never stalled by BUSY.

Engine:
- FSM states: IDLE, then STEP with a 2-bit byte counter.
- On DATA accept: work ← RESULT, move to STEP, counter = 0.
- Each STEP cycle processes byte data[31-8k] for k = 0..3, MSB byte first. The step is work ^= byte<<24, then 8 shift/conditional-XOR iterations with CRC_POLY, computed combinationally within one cycle.
- After k = 3: RESULT ← work, return to IDLE.
- RESULT keeps its pre-update value until the commit.
- CLEAR and SEED writes cannot overlap the engine, because writes stall while BUSY.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid: 0.
  - bresp, rresp, rdata: 0.
  - SEED and RESULT: SEED_RESET.
  - DATA: 0. FSM: IDLE.
- Reset asserted mid-operation aborts the engine, drops any pending bvalid/rvalid, and restores all of the above on the next edge.
- Write latency: handshake at edge T → bvalid visible at T+1.
- Read latency: handshake at edge T → rvalid at T+1.
- DATA write accepted at edge T:
  - BUSY reads 1 for edges T+1..T+4.
  - RESULT is updated and BUSY is 0 from edge T+4.
  - The earliest next write handshake is at edge T+5.
- A read and a write may both handshake in the same cycle. The read returns the pre-write register value.
- A write with awvalid high but wvalid low, or the reverse, is not accepted until both are present.

## Structure
- Package customcrc_pkg holds:
  - register offsets CTRL_OFS, SEED_OFS, DATA_OFS, RES_OFS;
  - the CTRL bit indices;
  - CRC32_POLY and SEED_RESET_VAL;
  - the engine FSM state enum.
- Sub-module customcrc_engine holds the FSM, byte counter, and work register.
  - Inputs: start, word, init.
  - Outputs: busy, done, crc.
- The top level holds the AXI channel handshakes and the register file.

## Test plan
- Reset, then read 0x0/0x4/0x8/0xC → 0x00000000, 0xFFFFFFFF, 0x00000000, 0xFFFFFFFF, all rresp OKAY.
- Write SEED=0 with strobe 0xF, write CTRL=1, write DATA=0x00000001 → RESULT reads 0x04C11DB7, DATA reads 0x00000001.
- Continue from SEED=0: CLEAR, then write DATA=0x00000002 → RESULT reads 0x09823B6E.
- SEED=0xFFFFFFFF, CLEAR, DATA=0xFFFFFFFF → RESULT 0x00000000.
  - Poll CTRL immediately after the bvalid handshake → BUSY=1 is observed.
  - A second DATA write issued during BUSY gets no awready until 5 cycles after the first handshake.
- Write SEED=0xDEAD0011 with wstrb=0x3 → SEED reads 0xFFFF0011. A write to 0xC returns bresp OKAY and leaves RESULT unchanged.
- Hold bready and rready low for 10 cycles → bvalid/rvalid and rdata stay stable and no new handshake is accepted. Assert reset during an engine run → BUSY=0 and RESULT=0xFFFFFFFF.

Source files
------------

// File: rtl/customcrc_pkg.sv
// Shared definitions for the customCRC AXI4-Lite peripheral: register map,
// CTRL bit positions, CRC constants, engine state type and helper functions.
package customcrc_pkg;

    // Byte offsets of the four registers (addr[1:0] is always ignored)
    localparam logic [3:0] CTRL_OFS = 4'h0;
    localparam logic [3:0] SEED_OFS = 4'h4;
    localparam logic [3:0] DATA_OFS = 4'h8;
    localparam logic [3:0] RES_OFS  = 4'hC;

    localparam int unsigned CTRL_CLEAR_BIT = 0;
    localparam int unsigned CTRL_BUSY_BIT  = 1;

    localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
    localparam logic [31:0] SEED_RESET_VAL = 32'hFFFFFFFF;

    typedef enum logic [0:0] {
        StIdle,
        StStep
    } eng_state_e;

    // One byte of MSB-first, non-reflected CRC-32
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data,
                                               input logic [31:0] poly);
        logic [31:0] c;
        c = crc ^ {data, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

    // Byte-lane merge of a write into an existing register value
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/customcrc_axil_slave_if.sv
// AXI4-Lite bus bundle for the customCRC S00_AXI port.
interface customcrc_axil_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/customcrc_engine.sv
// Byte-serial CRC-32 engine: folds one 32-bit word into a running CRC,
// MSB byte first, one byte per cycle.
module customcrc_engine
    import customcrc_pkg::*;
#(
    parameter logic [31:0] CRC_POLY = CRC32_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [31:0] init,
    output logic        busy,
    output logic        done,
    output logic [31:0] crc
);

    eng_state_e  state_q;
    logic [1:0]  cnt_q;
    logic [31:0] work_q;
    logic [31:0] word_q;
    logic [7:0]  cur_byte;
    logic [31:0] step;

    // Select byte k (MSB first) and compute this cycle's CRC step
    always_comb begin
        cur_byte = 8'h00;
        unique case (cnt_q)
            2'd0: cur_byte = word_q[31:24];
            2'd1: cur_byte = word_q[23:16];
            2'd2: cur_byte = word_q[15:8];
            2'd3: cur_byte = word_q[7:0];
        endcase
        step = crc32_byte(work_q, cur_byte, CRC_POLY);
    end

    // done marks the final step so the owner can commit crc on the same edge
    assign busy = (state_q == StStep);
    assign done = busy && (cnt_q == 2'd3);
    assign crc  = step;

    // Engine FSM: IDLE waits for start, STEP walks the four bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            work_q  <= '0;
            word_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q  <= init;
                        word_q  <= word;
                        cnt_q   <= 2'd0;
                        state_q <= StStep;
                    end
                end
                StStep: begin
                    work_q <= step;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/customcrc_axil_slave.sv
// AXI4-Lite slave front end for the CRC-32 peripheral: channel handshakes,
// CTRL/SEED/DATA/RESULT register file and the engine instance.
module customcrc_axil_slave
    import customcrc_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] CRC_POLY           = CRC32_POLY,
    parameter logic [31:0] SEED_RESET         = SEED_RESET_VAL
) (
    input logic                   s00_axi_aclk,
    input logic                   s00_axi_areset,
    customcrc_axil_slave_if.slave s00_axi
);

    logic [C_S_AXI_DATA_WIDTH-1:0] seed_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] result_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] data_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] data_merged;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_ofs;
    logic [C_S_AXI_ADDR_WIDTH-1:0] rd_ofs;

    logic awready_q;
    logic bvalid_q;
    logic arready_q;
    logic rvalid_q;
    logic wr_hs;
    logic rd_hs;
    logic eng_start;
    logic eng_busy;
    logic eng_done;
    logic [31:0] eng_crc;

    logic unused_axi;
    assign unused_axi = ^{s00_axi.awprot, s00_axi.arprot,
                          s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign wr_ofs = {s00_axi.awaddr[3:2], 2'b00};
    assign rd_ofs = {s00_axi.araddr[3:2], 2'b00};

    // awready and wready are one shared pulse, so both channels accept together
    assign wr_hs = awready_q && s00_axi.awvalid && s00_axi.wvalid;
    assign rd_hs = arready_q && s00_axi.arvalid;

    assign data_merged = apply_wstrb(data_q, s00_axi.wdata, s00_axi.wstrb);
    assign eng_start   = wr_hs && (wr_ofs == DATA_OFS);

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;

    customcrc_engine #(
        .CRC_POLY (CRC_POLY)
    ) u_engine (
        .clk   (s00_axi_aclk),
        .rst   (s00_axi_areset),
        .start (eng_start),
        .word  (data_merged),
        .init  (result_q),
        .busy  (eng_busy),
        .done  (eng_done),
        .crc   (eng_crc)
    );

    // Write channel: ready may rise during the engine's last step so the next
    // write lands on the edge right after the commit
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= !awready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q &&
                         (!eng_busy || eng_done);
            if (wr_hs) begin
                bvalid_q <= 1'b1;
            end else if (s00_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register file updates from bus writes and engine commit
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            seed_q   <= SEED_RESET;
            result_q <= SEED_RESET;
            data_q   <= '0;
        end else begin
            if (eng_done) begin
                result_q <= eng_crc;
            end
            if (wr_hs) begin
                unique case (wr_ofs)
                    CTRL_OFS: begin
                        if (s00_axi.wstrb[0] && s00_axi.wdata[CTRL_CLEAR_BIT]) begin
                            result_q <= seed_q;
                        end
                    end
                    SEED_OFS: seed_q <= apply_wstrb(seed_q, s00_axi.wdata, s00_axi.wstrb);
                    DATA_OFS: data_q <= data_merged;
                    default: ;
                endcase
            end
        end
    end

    // Read data mux; CLEAR always reads back as 0
    always_comb begin
        rd_mux = '0;
        unique case (rd_ofs)
            CTRL_OFS: rd_mux[CTRL_BUSY_BIT] = eng_busy;
            SEED_OFS: rd_mux = seed_q;
            DATA_OFS: rd_mux = data_q;
            RES_OFS:  rd_mux = result_q;
            default:  rd_mux = '0;
        endcase
    end

    // Read channel: rdata captured at the handshake and held until rready
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= !arready_q && s00_axi.arvalid && !rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
